data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master arbiter and transaction sequencer for the shared data bus. Master 0 is the core's load/store port. Master 1 is a secondary requester such as a DMA or debug port. The block grants one master at a time, drives registered bus outputs for the duration of a transaction, waits on a slave `bus_ready` handshake with a timeout, and returns read data together with a one-cycle completion pulse to the owning master. It sits between the core's data memory interface and the system data bus.

## Interface
- `TIMEOUT_CYCLES`, 255: BUSY cycles without `bus_ready` before the transaction is aborted; 0 disables the timeout; legal range 0..65535.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_address`, `m1_address`  in  32  request address.
- `m0_write_data`, `m1_write_data`  in  32  store data.
- `m0_byte_enable`, `m1_byte_enable`  in  4  byte lanes.
- `m0_read_enable`, `m1_read_enable`  in  1  read request.
- `m0_write_enable`, `m1_write_enable`  in  1  write request.
- `m0_read_data`, `m1_read_data`  out  32  registered read result.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_error`, `m1_error`  out  1  qualifies `mX_ready`: transaction timed out.
- `bus_address`  out  32  registered bus address.
- `bus_write_data`  out  32  registered bus store data.
- `bus_byte_enable`  out  4  registered bus byte lanes.
- `bus_read_enable`, `bus_write_enable`  out  1  registered bus strobes.
- `bus_read_data`  in  32  slave read data, valid when `bus_ready`=1.
- `bus_ready`  in  1  slave completion.
- `grant`  out  2  one-hot current owner; 00 when idle.

## Operation
- Request: `mX_req = mX_read_enable | mX_write_enable`. If both enables are set, the request is a write and `bus_read_enable` stays 0.
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE with no request: all bus outputs 0; stay in IDLE.
- IDLE with at least one request:
  - Pick the winner.
  - Latch the winner's address, write_data, byte_enable and strobes into the bus registers.
  - Set `grant`, clear the timeout counter, go to BUSY.
- BUSY with `bus_ready`=1:
  - On a read, capture `bus_read_data` into the owner's `read_data`.
  - Set the owner's `ready` and clear its `error`.
  - Clear the bus strobes and go to DONE.
- BUSY with `bus_ready`=0:
  - If `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`-1: abort. Clear strobes, set the owner's `ready` and `error`, set the owner's `read_data`=0, go to DONE.
  - Otherwise increment the counter (16 bit, saturating) and stay in BUSY.
- DONE: clear `ready`, `error` and `grant`; requests are ignored; go to IDLE.
- `mX_read_data` changes only on a read completion or an abort of that master. Write completions leave it unchanged.
- Requesters hold address, data and enables stable from request until they see `ready`. Inputs are not re-sampled after IDLE.
- Asserting `reset_n`=0 mid-transaction abandons the transaction immediately. No `ready` pulse is produced.

## Timing
- Reset values:
  - All outputs 0, `grant`=00, state IDLE.
  - Timeout counter 0.
  - Round-robin pointer `last`=1, so master 0 wins the first contention.
- Minimum latency, zero-wait slave:
  - Request seen in IDLE at cycle 0.
  - Bus strobes valid in cycle 1; `bus_ready`=1 in cycle 1.
  - `mX_ready` high in cycle 2, state DONE.
  - Next request accepted in cycle 3 at the earliest.
- Each slave wait cycle adds one cycle of latency.
- Bus outputs are driven only from registers, so there are no combinational paths from master inputs to bus outputs.
- `bus_ready` is ignored outside BUSY.
- With `TIMEOUT_CYCLES`=N, an unresponsive slave keeps the bus strobes high for exactly N cycles. `ready`+`error` rise on the edge after the Nth BUSY cycle.
- `bus_ready`=1 in the same cycle the counter reaches N-1 counts as a normal completion; the timeout does not win.

## Configuration
- `DATA_BUS_ARBITER_ROUND_ROBIN_EN` defined:
  - On contention the master not equal to `last` wins.
  - `last` updates to the winner on every grant, so simultaneous continuous requests alternate 0,1,0,1.
- Macro undefined:
  - Fixed priority: master 0 always wins contention; master 1 is served only when master 0 is idle.
  - The `last` register is not implemented.

## Test plan
- Single m0 read at 0x0000_0100, slave returns 0xDEAD_BEEF with zero wait: bus strobes in cycle 1, `m0_ready`=1 and `m0_read_data`=0xDEAD_BEEF in cycle 2, `grant`=00 in cycle 3.
- m1 write 0xCAFE_F00D, byte_enable 0011, slave waits 3 cycles: bus strobes stay high for 4 cycles; `m1_ready` pulses once; `m1_read_data` unchanged.
- Both masters request continuously for 4 transactions:
  - With the macro, grant order is m0, m1, m0, m1.
  - Without the macro, grant order is m0, m0, m0, m0 and m1 is never granted.
- `TIMEOUT_CYCLES`=4, slave never ready: strobes high for exactly 4 cycles, then `m0_ready`=1, `m0_error`=1, `m0_read_data`=0; the next m0 request completes normally.
- `reset_n` pulled low in cycle 2 of a waited m1 read: all outputs 0 immediately, no `m1_ready` pulse, next request restarts from IDLE with m0 priority.
- m0 asserts read_enable and write_enable together: bus shows a write only, with `bus_read_enable`=0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: grants one master, drives registered bus strobes until bus_ready or timeout, then pulses ready for one cycle.
// Latency: zero-wait slave completes 2 cycles after the request is seen. Contention: fixed m0 priority, or round robin with DATA_BUS_ARBITER_ROUND_ROBIN_EN.
module data_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] m0_address_i,
  input  logic [31:0] m1_address_i,
  input  logic [31:0] m0_write_data_i,
  input  logic [31:0] m1_write_data_i,
  input  logic [3:0]  m0_byte_enable_i,
  input  logic [3:0]  m1_byte_enable_i,
  input  logic        m0_read_enable_i,
  input  logic        m1_read_enable_i,
  input  logic        m0_write_enable_i,
  input  logic        m1_write_enable_i,
  output logic [31:0] m0_read_data_o,
  output logic [31:0] m1_read_data_o,
  output logic        m0_ready_o,
  output logic        m1_ready_o,
  output logic        m0_error_o,
  output logic        m1_error_o,
  output logic [31:0] bus_address_o,
  output logic [31:0] bus_write_data_o,
  output logic [3:0]  bus_byte_enable_o,
  output logic        bus_read_enable_o,
  output logic        bus_write_enable_o,
  input  logic [31:0] bus_read_data_i,
  input  logic        bus_ready_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } bus_req_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  bus_req_t         bus_q;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic [1:0]       grant_q;
  logic [1:0]       ready_q;
  logic [1:0]       error_q;
  logic [1:0][31:0] rdata_q;

  bus_req_t m0_bus;
  bus_req_t m1_bus;
  bus_req_t win_bus;
  logic     m0_req;
  logic     m1_req;
  logic     win1;

  // A simultaneous read+write request is treated as a write only.
  assign m0_bus = '{addr: m0_address_i, wdata: m0_write_data_i, be: m0_byte_enable_i,
                    rd: m0_read_enable_i & ~m0_write_enable_i, wr: m0_write_enable_i};
  assign m1_bus = '{addr: m1_address_i, wdata: m1_write_data_i, be: m1_byte_enable_i,
                    rd: m1_read_enable_i & ~m1_write_enable_i, wr: m1_write_enable_i};

  assign m0_req = m0_read_enable_i | m0_write_enable_i;
  assign m1_req = m1_read_enable_i | m1_write_enable_i;

`ifdef DATA_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_q;
  // last_q=1 means m1 owned the bus last, so m0 wins the next contention.
  assign win1 = m1_req & (~m0_req | ~last_q);
`else
  assign win1 = m1_req & ~m0_req;
`endif

  assign win_bus = win1 ? m1_bus : m0_bus;
  assign cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      bus_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ready_q <= '0;
      error_q <= '0;
      rdata_q <= '0;
`ifdef DATA_BUS_ARBITER_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req | m1_req) begin
            bus_q   <= win_bus;
            grant_q <= win1 ? 2'b10 : 2'b01;
            cnt_q   <= '0;
            state_q <= BUSY;
`ifdef DATA_BUS_ARBITER_ROUND_ROBIN_EN
            last_q  <= win1;
`endif
          end else begin
            bus_q <= '0;
          end
        end
        BUSY: begin
          if (bus_ready_i) begin
            if (bus_q.rd) begin
              rdata_q[grant_q[1]] <= bus_read_data_i;
            end
            ready_q  <= grant_q;
            error_q  <= 2'b00;
            bus_q.rd <= 1'b0;
            bus_q.wr <= 1'b0;
            state_q  <= DONE;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            rdata_q[grant_q[1]] <= '0;
            ready_q  <= grant_q;
            error_q  <= grant_q;
            bus_q.rd <= 1'b0;
            bus_q.wr <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          ready_q <= '0;
          error_q <= '0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_read_data_o     = rdata_q[0];
  assign m1_read_data_o     = rdata_q[1];
  assign m0_ready_o         = ready_q[0];
  assign m1_ready_o         = ready_q[1];
  assign m0_error_o         = error_q[0];
  assign m1_error_o         = error_q[1];
  assign bus_address_o      = bus_q.addr;
  assign bus_write_data_o   = bus_q.wdata;
  assign bus_byte_enable_o  = bus_q.be;
  assign bus_read_enable_o  = bus_q.rd;
  assign bus_write_enable_o = bus_q.wr;
  assign grant_o            = grant_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter built with TIMEOUT_CYCLES=4; honours DATA_BUS_ARBITER_ROUND_ROBIN_EN.
module tb_data_bus_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] m0_address_i, m1_address_i, m0_write_data_i, m1_write_data_i;
  logic [3:0]  m0_byte_enable_i, m1_byte_enable_i;
  logic        m0_read_enable_i, m1_read_enable_i, m0_write_enable_i, m1_write_enable_i;
  logic [31:0] m0_read_data_o, m1_read_data_o;
  logic        m0_ready_o, m1_ready_o, m0_error_o, m1_error_o;
  logic [31:0] bus_address_o, bus_write_data_o;
  logic [3:0]  bus_byte_enable_o;
  logic        bus_read_enable_o, bus_write_enable_o;
  logic [31:0] bus_read_data_i;
  logic        bus_ready_i;
  logic [1:0]  grant_o;

  int ncmp = 0;
  int nfail = 0;

  data_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .m0_address_i(m0_address_i), .m1_address_i(m1_address_i),
    .m0_write_data_i(m0_write_data_i), .m1_write_data_i(m1_write_data_i),
    .m0_byte_enable_i(m0_byte_enable_i), .m1_byte_enable_i(m1_byte_enable_i),
    .m0_read_enable_i(m0_read_enable_i), .m1_read_enable_i(m1_read_enable_i),
    .m0_write_enable_i(m0_write_enable_i), .m1_write_enable_i(m1_write_enable_i),
    .m0_read_data_o(m0_read_data_o), .m1_read_data_o(m1_read_data_o),
    .m0_ready_o(m0_ready_o), .m1_ready_o(m1_ready_o),
    .m0_error_o(m0_error_o), .m1_error_o(m1_error_o),
    .bus_address_o(bus_address_o), .bus_write_data_o(bus_write_data_o),
    .bus_byte_enable_o(bus_byte_enable_o),
    .bus_read_enable_o(bus_read_enable_o), .bus_write_enable_o(bus_write_enable_o),
    .bus_read_data_i(bus_read_data_i), .bus_ready_i(bus_ready_i),
    .grant_o(grant_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address_i = '0; m1_address_i = '0;
    m0_write_data_i = '0; m1_write_data_i = '0;
    m0_byte_enable_i = '0; m1_byte_enable_i = '0;
    m0_read_enable_i = 1'b0; m1_read_enable_i = 1'b0;
    m0_write_enable_i = 1'b0; m1_write_enable_i = 1'b0;
    bus_read_data_i = '0; bus_ready_i = 1'b0;
  endtask

  // Drives one request from master m and acts as a slave that answers after
  // `waits` wait cycles (negative: never). Returns in IDLE, one cycle after DONE.
  task automatic do_txn(input int m, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int waits, input logic [31:0] rdata,
                        output int strobes, output logic err, output logic rdy_after,
                        output logic [31:0] s_wdata, output logic [3:0] s_be,
                        output logic s_we, output logic s_re, output logic [1:0] s_grant);
    bit done = 0;
    strobes = 0; err = 1'b0; rdy_after = 1'b1;
    s_wdata = '0; s_be = '0; s_we = 1'b0; s_re = 1'b0; s_grant = '0;
    if (m == 0) begin
      m0_address_i = addr; m0_write_data_i = wdata; m0_byte_enable_i = be;
      m0_read_enable_i = rd; m0_write_enable_i = wr;
    end else begin
      m1_address_i = addr; m1_write_data_i = wdata; m1_byte_enable_i = be;
      m1_read_enable_i = rd; m1_write_enable_i = wr;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (bus_read_enable_o || bus_write_enable_o) begin
        strobes++;
        s_wdata = bus_write_data_o; s_be = bus_byte_enable_o;
        s_we = bus_write_enable_o; s_re = bus_read_enable_o; s_grant = grant_o;
        bus_ready_i = (strobes == waits + 1);
        bus_read_data_i = rdata;
      end else begin
        bus_ready_i = 1'b0;
      end
      if ((m == 0) ? m0_ready_o : m1_ready_o) begin
        err = (m == 0) ? m0_error_o : m1_error_o;
        clear_inputs();
        tick();
        rdy_after = m0_ready_o | m1_ready_o;
        done = 1;
      end
    end
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL txn_completion: master %0d got no ready within 40 cycles, required one", m);
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    tick(); tick();
    reset_n_i = 1'b1;
    tick();
    ncmp++; if (grant_o !== 2'b00) begin nfail++; $display("FAIL reset_grant: got %b required 00", grant_o); end
    ncmp++; if ({bus_read_enable_o, bus_write_enable_o, bus_address_o} !== '0) begin
      nfail++; $display("FAIL reset_bus: got re=%b we=%b addr=%h required all 0",
                        bus_read_enable_o, bus_write_enable_o, bus_address_o); end
    ncmp++; if ({m0_ready_o, m1_ready_o, m0_error_o, m1_error_o, m0_read_data_o} !== '0) begin
      nfail++; $display("FAIL reset_master: got rdy=%b%b err=%b%b m0_rdata=%h required 0",
                        m0_ready_o, m1_ready_o, m0_error_o, m1_error_o, m0_read_data_o); end
  endtask

  task automatic test_single_read();
    m0_address_i = 32'h0000_0100; m0_read_enable_i = 1'b1;
    tick();
    ncmp++; if ({bus_read_enable_o, bus_write_enable_o} !== 2'b10) begin
      nfail++; $display("FAIL rd_strobes_c1: got re/we=%b%b required 10", bus_read_enable_o, bus_write_enable_o); end
    ncmp++; if (bus_address_o !== 32'h0000_0100) begin
      nfail++; $display("FAIL rd_addr_c1: got %h required 00000100", bus_address_o); end
    ncmp++; if (grant_o !== 2'b01) begin nfail++; $display("FAIL rd_grant_c1: got %b required 01", grant_o); end
    bus_ready_i = 1'b1; bus_read_data_i = 32'hDEAD_BEEF;
    tick();
    ncmp++; if ({m0_ready_o, m0_error_o} !== 2'b10) begin
      nfail++; $display("FAIL rd_ready_c2: got ready/error=%b%b required 10", m0_ready_o, m0_error_o); end
    ncmp++; if (m0_read_data_o !== 32'hDEAD_BEEF) begin
      nfail++; $display("FAIL rd_data_c2: got %h required deadbeef", m0_read_data_o); end
    ncmp++; if (bus_read_enable_o !== 1'b0) begin nfail++; $display("FAIL rd_strobe_drop_c2: got %b required 0", bus_read_enable_o); end
    clear_inputs();
    tick();
    ncmp++; if ({grant_o, m0_ready_o} !== 3'b000) begin
      nfail++; $display("FAIL rd_idle_c3: got grant=%b ready=%b required 00/0", grant_o, m0_ready_o); end
  endtask

  task automatic test_read_write_both();
    m0_address_i = 32'h0000_0200; m0_write_data_i = 32'h0BAD_F00D; m0_byte_enable_i = 4'hF;
    m0_read_enable_i = 1'b1; m0_write_enable_i = 1'b1;
    tick();
    ncmp++; if ({bus_read_enable_o, bus_write_enable_o} !== 2'b01) begin
      nfail++; $display("FAIL both_en_strobes: got re/we=%b%b required 01", bus_read_enable_o, bus_write_enable_o); end
    ncmp++; if (bus_write_data_o !== 32'h0BAD_F00D) begin
      nfail++; $display("FAIL both_en_wdata: got %h required 0badf00d", bus_write_data_o); end
    bus_ready_i = 1'b1; bus_read_data_i = 32'h1111_1111;
    tick();
    ncmp++; if (m0_ready_o !== 1'b1) begin nfail++; $display("FAIL both_en_ready: got %b required 1", m0_ready_o); end
    ncmp++; if (m0_read_data_o !== 32'hDEAD_BEEF) begin
      nfail++; $display("FAIL both_en_rdata_kept: got %h required deadbeef", m0_read_data_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_waited_write();
    int strobes; logic err, rdy_after, s_we, s_re; logic [31:0] s_wdata; logic [3:0] s_be; logic [1:0] s_grant;
    do_txn(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h1234_5678,
           strobes, err, rdy_after, s_wdata, s_be, s_we, s_re, s_grant);
    ncmp++; if (m1_read_data_o !== 32'h1234_5678) begin
      nfail++; $display("FAIL m1_read_data: got %h required 12345678", m1_read_data_o); end
    // Three wait cycles: bus_ready lands when the counter is at TIMEOUT-1.
    do_txn(1, 1'b0, 1'b1, 32'h0000_0304, 32'hCAFE_F00D, 4'b0011, 3, 32'hFFFF_FFFF,
           strobes, err, rdy_after, s_wdata, s_be, s_we, s_re, s_grant);
    ncmp++; if (strobes !== 4) begin nfail++; $display("FAIL wr_strobe_cycles: got %0d required 4", strobes); end
    ncmp++; if (err !== 1'b0) begin nfail++; $display("FAIL wr_edge_no_timeout: got error %b required 0", err); end
    ncmp++; if (rdy_after !== 1'b0) begin nfail++; $display("FAIL wr_ready_pulse: ready still %b next cycle, required 0", rdy_after); end
    ncmp++; if ({s_we, s_re, s_be, s_grant} !== {1'b1, 1'b0, 4'b0011, 2'b10}) begin
      nfail++; $display("FAIL wr_bus_fields: got we=%b re=%b be=%b grant=%b required 1/0/0011/10", s_we, s_re, s_be, s_grant); end
    ncmp++; if (s_wdata !== 32'hCAFE_F00D) begin nfail++; $display("FAIL wr_wdata: got %h required cafef00d", s_wdata); end
    ncmp++; if (m1_read_data_o !== 32'h1234_5678) begin
      nfail++; $display("FAIL wr_rdata_unchanged: got %h required 12345678", m1_read_data_o); end
  endtask

  task automatic test_timeout();
    int strobes; logic err, rdy_after, s_we, s_re; logic [31:0] s_wdata; logic [3:0] s_be; logic [1:0] s_grant;
    do_txn(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, -1, 32'hAAAA_AAAA,
           strobes, err, rdy_after, s_wdata, s_be, s_we, s_re, s_grant);
    ncmp++; if (strobes !== 4) begin nfail++; $display("FAIL to_strobe_cycles: got %0d required 4", strobes); end
    ncmp++; if (err !== 1'b1) begin nfail++; $display("FAIL to_error: got %b required 1", err); end
    ncmp++; if (m0_read_data_o !== 32'h0) begin nfail++; $display("FAIL to_rdata_zero: got %h required 00000000", m0_read_data_o); end
    ncmp++; if (rdy_after !== 1'b0) begin nfail++; $display("FAIL to_ready_pulse: ready still %b next cycle, required 0", rdy_after); end
    do_txn(0, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'hF, 0, 32'h55AA_33CC,
           strobes, err, rdy_after, s_wdata, s_be, s_we, s_re, s_grant);
    ncmp++; if ({strobes == 1, err} !== 2'b10) begin
      nfail++; $display("FAIL to_recover: got strobes=%0d error=%b required 1/0", strobes, err); end
    ncmp++; if (m0_read_data_o !== 32'h55AA_33CC) begin
      nfail++; $display("FAIL to_recover_data: got %h required 55aa33cc", m0_read_data_o); end
  endtask

  task automatic test_contention();
    logic [1:0] order[4];
    logic [1:0] exp_order[4];
    int idx = 0;
`ifdef DATA_BUS_ARBITER_ROUND_ROBIN_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    m0_address_i = 32'h0000_0500; m0_read_enable_i = 1'b1;
    m1_address_i = 32'h0000_0600; m1_read_enable_i = 1'b1;
    for (int c = 0; c < 60 && idx < 4; c++) begin
      tick();
      if (bus_read_enable_o) begin
        order[idx] = grant_o;
        idx++;
        bus_ready_i = 1'b1;
      end else begin
        bus_ready_i = 1'b0;
      end
    end
    m0_read_enable_i = 1'b0; m1_read_enable_i = 1'b0;
    tick();
    bus_ready_i = 1'b0;
    tick();
    if (idx < 4) begin
      ncmp++; nfail++;
      $display("FAIL contention_progress: got %0d grants in 60 cycles, required 4", idx);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ncmp++;
        if (order[i] !== exp_order[i]) begin
          nfail++; $display("FAIL contention_grant_%0d: got %b required %b", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    m1_address_i = 32'h0000_0700; m1_read_enable_i = 1'b1;
    tick();
    tick();
    reset_n_i = 1'b0;
    #1;
    ncmp++; if ({bus_read_enable_o, bus_address_o, grant_o} !== '0) begin
      nfail++; $display("FAIL rst_mid_bus: got re=%b addr=%h grant=%b required 0", bus_read_enable_o, bus_address_o, grant_o); end
    ncmp++; if ({m1_ready_o, m1_read_data_o} !== '0) begin
      nfail++; $display("FAIL rst_mid_master: got ready=%b rdata=%h required 0", m1_ready_o, m1_read_data_o); end
    m1_read_enable_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m1_ready_o) stray++;
    end
    ncmp++; if (stray !== 0) begin nfail++; $display("FAIL rst_mid_no_ready: got %0d pulses required 0", stray); end
    m0_address_i = 32'h0000_0800; m0_read_enable_i = 1'b1;
    m1_address_i = 32'h0000_0900; m1_read_enable_i = 1'b1;
    tick();
    ncmp++; if ({grant_o, bus_address_o} !== {2'b01, 32'h0000_0800}) begin
      nfail++; $display("FAIL rst_mid_m0_priority: got grant=%b addr=%h required 01/00000800", grant_o, bus_address_o); end
    bus_ready_i = 1'b1; bus_read_data_i = 32'h0F0F_0F0F;
    tick();
    ncmp++; if ({m0_ready_o, m0_read_data_o} !== {1'b1, 32'h0F0F_0F0F}) begin
      nfail++; $display("FAIL rst_mid_restart: got ready=%b rdata=%h required 1/0f0f0f0f", m0_ready_o, m0_read_data_o); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read_write_both();
    test_waited_write();
    test_timeout();
    test_contention();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
